// File: rtl/vid_pos_gen.sv
// -----------------------------------------------------------------------------
// vid_pos_gen
//
// Front end of the logo/detect path. It parses an Avalon-ST Video stream
// (24-bit beats, 3 symbols in parallel) and forwards every beat through a
// one-deep register slice with backpressure. Each forwarded video pixel carries
// its (cnt_x, cnt_y) coordinate, and pix_valid marks real pixels. Control
// packets update the frame dimensions. Protocol errors produce 1-cycle pulses.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   din_*               input stream (data/valid/sop/eop), din_ready back
//   dout_*              registered output stream, dout_ready from downstream
//   pix_valid           dout_valid and the beat is a video-packet pixel
//   cnt_x, cnt_y        coordinate of the dout pixel (FFFF once past frame end)
//   frame_width/height  dimensions applied at the next video packet
//   err_short           video packet ended or was aborted before it was full
//   err_long            first pixel beyond width*height in a frame
//   err_ctrl            control packet rejected (too short or zero dimension)
// -----------------------------------------------------------------------------
module vid_pos_gen #(
   parameter int unsigned DEF_WIDTH  = 640,
   parameter int unsigned DEF_HEIGHT = 480
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] din_data,
   input  logic        din_valid,
   input  logic        din_sop,
   input  logic        din_eop,
   output logic        din_ready,
   output logic [23:0] dout_data,
   output logic        dout_valid,
   output logic        dout_sop,
   output logic        dout_eop,
   input  logic        dout_ready,
   output logic        pix_valid,
   output logic [15:0] cnt_x,
   output logic [15:0] cnt_y,
   output logic [15:0] frame_width,
   output logic [15:0] frame_height,
   output logic        err_short,
   output logic        err_long,
   output logic        err_ctrl
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_VIDEO,
      S_CTRL,
      S_SKIP
   } state_t;

   localparam logic [3:0] TYPE_VIDEO = 4'h0;
   localparam logic [3:0] TYPE_CTRL  = 4'hF;

   state_t      state, state_nxt;
   logic        acc;

   // Video packet tracking
   logic [15:0] cur_w, cur_h;
   logic [15:0] pos_x, pos_y;
   logic [31:0] pix_cnt;          // pixels delivered in-frame (stops at total)
   logic [31:0] frame_total;
   logic        over;             // frame already ran past width*height
   logic        excess;

   // Control packet decode
   logic [1:0]  nib_cnt;          // nibble beats seen, saturating at 3
   logic [15:0] w_acc, h_acc;
   logic [15:0] w_nxt, h_nxt;
   logic [3:0]  n0, n1, n2;

   // Per-beat decisions from the parser
   logic        beat_pix;
   logic [15:0] pix_x, pix_y;
   logic        set_short, set_long, set_ctrl;
   logic        commit, start_video, start_ctrl, video_beat, ctrl_beat;

   assign din_ready   = dout_ready | ~dout_valid;
   assign acc         = din_valid & din_ready;
   assign frame_total = 32'(cur_w) * 32'(cur_h);
   assign excess      = over | (pix_cnt == frame_total);

   assign n0 = din_data[3:0];
   assign n1 = din_data[11:8];
   assign n2 = din_data[19:16];

   // Dimension fields after merging the current beat's nibbles.
   always_comb begin : nibble_merge
      // NOTE: every output of a combinational block gets a default first so no
      // path leaves it unassigned, which would otherwise infer a latch.
      w_nxt = w_acc;
      h_nxt = h_acc;
      unique case (nib_cnt)
         2'd0: begin
            w_nxt[15:12] = n0;
            w_nxt[11:8]  = n1;
            w_nxt[7:4]   = n2;
         end
         2'd1: begin
            w_nxt[3:0]   = n0;
            h_nxt[15:12] = n1;
            h_nxt[11:8]  = n2;
         end
         2'd2: begin
            h_nxt[7:4]   = n0;
            h_nxt[3:0]   = n1;
         end
         default: ;              // beats after the third are ignored
      endcase
   end

   always_comb begin : parse_comb
      state_nxt   = state;
      beat_pix    = 1'b0;
      pix_x       = 16'd0;
      pix_y       = 16'd0;
      set_short   = 1'b0;
      set_long    = 1'b0;
      set_ctrl    = 1'b0;
      commit      = 1'b0;
      start_video = 1'b0;
      start_ctrl  = 1'b0;
      video_beat  = 1'b0;
      ctrl_beat   = 1'b0;
      if (acc) begin
         if (din_sop) begin
            // A sop inside a packet aborts it; an unfinished frame is short.
            if (state == S_VIDEO && !over && pix_cnt < frame_total)
               set_short = 1'b1;
            state_nxt = S_IDLE;
            if (din_data[3:0] == TYPE_VIDEO) begin
               start_video = 1'b1;
               if (din_eop)
                  set_short = 1'b1;    // header-only video packet
               else
                  state_nxt = S_VIDEO;
            end else if (din_data[3:0] == TYPE_CTRL) begin
               start_ctrl = 1'b1;
               if (din_eop)
                  set_ctrl = 1'b1;     // no nibble beats at all
               else
                  state_nxt = S_CTRL;
            end else if (!din_eop) begin
               state_nxt = S_SKIP;
            end
         end else begin
            unique case (state)
               S_VIDEO: begin
                  video_beat = 1'b1;
                  beat_pix   = 1'b1;
                  if (excess) begin
                     pix_x    = 16'hFFFF;
                     pix_y    = 16'hFFFF;
                     set_long = ~over;
                  end else begin
                     pix_x = pos_x;
                     pix_y = pos_y;
                  end
                  if (din_eop) begin
                     state_nxt = S_IDLE;
                     // This beat counts as delivered, hence the +1.
                     if (!excess && (pix_cnt + 32'd1) < frame_total)
                        set_short = 1'b1;
                  end
               end
               S_CTRL: begin
                  ctrl_beat = 1'b1;
                  if (din_eop) begin
                     state_nxt = S_IDLE;
                     if (nib_cnt >= 2'd2 && w_nxt != 16'd0 && h_nxt != 16'd0)
                        commit = 1'b1;
                     else
                        set_ctrl = 1'b1;
                  end
               end
               S_SKIP: begin
                  if (din_eop)
                     state_nxt = S_IDLE;
               end
               default: ;              // IDLE: stray beats pass through
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin : state_reg
      if (rst)
         state <= S_IDLE;
      else
         // NOTE: sequential state uses non-blocking assignment so every
         // register samples pre-edge values regardless of statement order.
         state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin : datapath_reg
      if (rst) begin
         dout_data    <= '0;
         dout_valid   <= 1'b0;
         dout_sop     <= 1'b0;
         dout_eop     <= 1'b0;
         pix_valid    <= 1'b0;
         cnt_x        <= '0;
         cnt_y        <= '0;
         err_short    <= 1'b0;
         err_long     <= 1'b0;
         err_ctrl     <= 1'b0;
         frame_width  <= 16'(DEF_WIDTH);
         frame_height <= 16'(DEF_HEIGHT);
         cur_w        <= 16'(DEF_WIDTH);
         cur_h        <= 16'(DEF_HEIGHT);
         pos_x        <= '0;
         pos_y        <= '0;
         pix_cnt      <= '0;
         over         <= 1'b0;
         nib_cnt      <= '0;
         w_acc        <= '0;
         h_acc        <= '0;
      end else begin
         err_short <= set_short;
         err_long  <= set_long;
         err_ctrl  <= set_ctrl;

         // Output slice: load on accept, drain when downstream takes it,
         // otherwise hold everything (including coordinates) while stalled.
         if (acc) begin
            dout_data  <= din_data;
            dout_sop   <= din_sop;
            dout_eop   <= din_eop;
            dout_valid <= 1'b1;
            pix_valid  <= beat_pix;
            cnt_x      <= pix_x;
            cnt_y      <= pix_y;
         end else if (dout_ready) begin
            dout_valid <= 1'b0;
            pix_valid  <= 1'b0;
         end

         if (start_video) begin
            cur_w   <= frame_width;
            cur_h   <= frame_height;
            pos_x   <= '0;
            pos_y   <= '0;
            pix_cnt <= '0;
            over    <= 1'b0;
         end else if (video_beat) begin
            if (excess) begin
               over <= 1'b1;
            end else begin
               pix_cnt <= pix_cnt + 32'd1;
               if (pos_x == cur_w - 16'd1) begin
                  pos_x <= '0;
                  pos_y <= pos_y + 16'd1;
               end else begin
                  pos_x <= pos_x + 16'd1;
               end
            end
         end

         if (start_ctrl) begin
            nib_cnt <= '0;
            w_acc   <= '0;
            h_acc   <= '0;
         end else if (ctrl_beat) begin
            w_acc <= w_nxt;
            h_acc <= h_nxt;
            if (nib_cnt != 2'd3)
               nib_cnt <= nib_cnt + 2'd1;
         end

         if (commit) begin
            frame_width  <= w_nxt;
            frame_height <= h_nxt;
         end
      end
   end

endmodule
